kr580_uart_port: RTL and testbench
==================================

Name: kr580_uart_port

Overview:
- Serial port peripheral on the KR580 CPU's I/O-port bus (pa/pi/po/pw pins) at 25 MHz system clock, with interrupt request into the CPU intr pin.
- Consumes CPU OUT writes.
- Provides IN data.
- 8N1 transmitter with TX FIFO, single-byte receiver with error flags.

Parameters:
BASE, 8'h10, base I/O port; occupies BASE..BASE+2.
CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz / 115200).
TX_DEPTH_LOG2, 3, TX FIFO depth = 2^TX_DEPTH_LOG2 entries.

Ports:
clk  in  1  system clock, 25 MHz; CPU strobes are slower (clk/4 domain, same edge family).
rst  in  1  synchronous active-high reset.
port_addr  in  8  CPU port address (pin_pa).
port_wdata  in  8  CPU OUT data (pin_po).
port_we  in  1  CPU port write strobe (pin_pw), level; may stay high several clk cycles.
port_rdata  out  8  IN data to CPU (pin_pi).
uart_rx  in  1  serial input, asynchronous.
uart_tx  out  1  serial output, idle high.
intr  out  1  level interrupt request to CPU.

Behaviour:
- Reset values: uart_tx=1, intr=0, port_rdata=0, FIFO empty, rx_valid=0, ovr=0, ferr=0, ctrl=0, TX/RX FSMs IDLE.
- Write event = rising edge of port_we (registered previous value); exactly one write per strobe regardless of its length.
- Register map:
  - BASE+0 W: push port_wdata into TX FIFO; dropped silently if full.
  - BASE+0 R: rx_data.
  - BASE+1 W: command. bit0=1 pops RX (rx_valid<=0). bit1=1 clears ovr and ferr.
  - BASE+1 R: status {2'b0, ferr, ovr, tx_busy, tx_empty, tx_full, rx_valid}.
  - BASE+2 R/W: ctrl {4'b0, loop, tx_ie, rx_ie, 1'b0}. Bits 7:4 and 0 read 0; loop bit reads 0 without macro.
- Reads have no side effects.
- port_rdata is registered: value for port_addr at edge N appears after edge N. Unmapped address -> 8'h00.
- TX FIFO: circular, wrap-around pointers, count of TX_DEPTH_LOG2+1 bits.
- Push and pop in the same cycle: count unchanged. Push is accepted if count was full at that cycle and a pop occurs.
- TX FSM:
  - IDLE: if FIFO non-empty, pop into shifter -> START.
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx=1 -> IDLE.
  - Each state/bit lasts exactly CLKS_PER_BIT clk.
  - tx_busy=1 when not IDLE.
  - Back-to-back bytes: no idle gap beyond one clk.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: falling edge -> START.
  - START: at CLKS_PER_BIT/2 sample; if high -> IDLE (glitch), else DATA.
  - DATA: sample each bit at mid-bit, 8 bits LSB first.
  - STOP: sample at mid-bit.
    - Stop=0: ferr<=1, byte discarded.
    - Stop=1 and rx_valid=0: rx_data<=byte, rx_valid<=1.
    - Stop=1 and rx_valid=1: ovr<=1, old byte kept.
  - Return to IDLE at mid-stop sample.
- Same-cycle pop command and byte completion: new byte loaded, rx_valid=1, no overrun.
- intr (registered) = (rx_ie & rx_valid) | (tx_ie & tx_empty & !tx_busy).
- Reset mid-frame: uart_tx forced high next cycle, FIFO contents lost, RX frame abandoned.

Optional Feature:
UART_LOOPBACK_EN:
- Defined: ctrl bit3 (loop) is implemented. When loop=1, the RX synchronizer input is uart_tx instead of uart_rx; uart_tx still drives the pin.
- Undefined: bit3 is not stored, reads 0, and RX always uses uart_rx.

Test Plan:
- Reset: rst high 2 clk -> uart_tx=1, intr=0, port_rdata=0; read BASE+1 -> 8'h04.
- CLKS_PER_BIT=4, OUT BASE+0 = 8'hA5 with port_we held 4 clk -> exactly one frame. Line: 0, 1,0,1,0,0,1,0,1, 1, each level 4 clk. Status reads tx_busy=1 during the frame.
- TX_DEPTH_LOG2=2: push 6 bytes 01..06 while TX is stalled in its first frame -> tx_full=1. Byte 06 is dropped. Output order is 01..05.
- Drive serial 8'h3C on uart_rx -> rx_valid=1, IN BASE+0 = 8'h3C; with rx_ie=1, intr=1. OUT BASE+1 = 8'h01 -> rx_valid=0, intr=0 within 2 clk.
- Second byte 8'h77 arrives without pop -> ovr=1, rx_data stays 8'h3C. Frame with stop=0 -> ferr=1. OUT BASE+1 = 8'h02 clears both.
- With UART_LOOPBACK_EN, ctrl=8'h08, OUT BASE+0 = 8'h5A -> rx_valid=1, rx_data=8'h5A, uart_rx ignored (held 0).

Source files
------------

// File: rtl/kr580_uart_port.sv
// KR580 I/O-port UART: 8N1 transmitter behind a TX FIFO, single-byte receiver with overrun/framing flags.
// Optional feature macro: UART_LOOPBACK_EN (ctrl bit3 routes uart_tx back into the receiver).
module kr580_uart_port #(
  parameter logic [7:0]  BASE          = 8'h10,
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned TX_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_addr,
  input  logic [7:0] port_wdata,
  input  logic       port_we,
  output logic [7:0] port_rdata,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       intr
);

  localparam int unsigned DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned CNTW  = TX_DEPTH_LOG2 + 1;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  localparam logic [7:0]      ADDR_DATA = BASE;
  localparam logic [7:0]      ADDR_CMD  = BASE + 8'd1;
  localparam logic [7:0]      ADDR_CTRL = BASE + 8'd2;
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(HALF - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- write strobe
  logic we_q;
  logic wr_c, push_req_c, cmd_c, ctrl_wr_c, pop_cmd_c, clr_cmd_c;

  always_ff @(posedge clk) begin
    if (rst) we_q <= 1'b0;
    else     we_q <= port_we;
  end

  assign wr_c       = port_we & ~we_q;
  assign push_req_c = wr_c && (port_addr == ADDR_DATA);
  assign cmd_c      = wr_c && (port_addr == ADDR_CMD);
  assign ctrl_wr_c  = wr_c && (port_addr == ADDR_CTRL);
  assign pop_cmd_c  = cmd_c & port_wdata[0];
  assign clr_cmd_c  = cmd_c & port_wdata[1];

  // ---------------------------------------------------------------- control register
  logic ctrl_rx_ie, ctrl_tx_ie, ctrl_loop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rx_ie <= 1'b0;
      ctrl_tx_ie <= 1'b0;
    end else if (ctrl_wr_c) begin
      ctrl_rx_ie <= port_wdata[1];
      ctrl_tx_ie <= port_wdata[2];
    end
  end

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst)            ctrl_loop <= 1'b0;
    else if (ctrl_wr_c) ctrl_loop <= port_wdata[3];
  end
`else
  assign ctrl_loop = 1'b0;
`endif

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]               fifo_mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0]          fifo_cnt;
  logic                     fifo_full_c, fifo_empty_c, push_c, tx_pop_c;

  assign fifo_full_c  = (fifo_cnt == FULL_CNT);
  assign fifo_empty_c = (fifo_cnt == '0);
  // A full FIFO still accepts a push when the transmitter pops in the same cycle
  assign push_c       = push_req_c && (!fifo_full_c || tx_pop_c);

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= port_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_c)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop_c) rd_ptr <= rd_ptr + 1'b1;
      case ({push_c, tx_pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          tx_line_c, tx_busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      uart_tx  <= tx_line_c;
    end
  end

  // Line level follows the state one clk later, so every symbol still lasts CLKS_PER_BIT
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_line_c    = 1'b1;
    tx_pop_c     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty_c) begin
          tx_pop_c     = 1'b1;
          tx_shift_nxt = fifo_mem[rd_ptr];
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_line_c = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx_line_c = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
          else                tx_bit_nxt   = tx_bit + 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        tx_line_c = 1'b1;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  assign tx_busy_c = (tx_state != TX_IDLE);

  // ---------------------------------------------------------------- RX synchronizer
  logic rx_in_c, rx_s1, rx_s2, rx_prev;

  assign rx_in_c = ctrl_loop ? uart_tx : uart_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in_c;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_done_c, rx_ferr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // Start is checked at half a bit, after which every sample lands mid-bit
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done_c    = 1'b0;
    rx_ferr_c    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 1'b1;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_IDLE;
          rx_done_c    = rx_s2;
          rx_ferr_c    = !rx_s2;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX holding register and flags
  logic [7:0] rx_data;
  logic       rx_valid, ovr, ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (clr_cmd_c) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
      end
      if (rx_ferr_c) ferr <= 1'b1;
      // A pop arriving with a completed byte frees the slot, so it is not an overrun
      if (rx_done_c) begin
        if (!rx_valid || pop_cmd_c) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (pop_cmd_c) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- read mux and interrupt
  logic [7:0] status_c, ctrl_rd_c;

  assign status_c  = {2'b00, ferr, ovr, tx_busy_c, fifo_empty_c, fifo_full_c, rx_valid};
  assign ctrl_rd_c = {4'b0000, ctrl_loop, ctrl_tx_ie, ctrl_rx_ie, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      port_rdata <= '0;
      intr       <= 1'b0;
    end else begin
      case (port_addr)
        ADDR_DATA: port_rdata <= rx_data;
        ADDR_CMD:  port_rdata <= status_c;
        ADDR_CTRL: port_rdata <= ctrl_rd_c;
        default:   port_rdata <= 8'h00;
      endcase
      intr <= (ctrl_rx_ie & rx_valid) | (ctrl_tx_ie & fifo_empty_c & ~tx_busy_c);
    end
  end

endmodule

// File: tb/tb_kr580_uart_port.sv
// Directed bench for kr580_uart_port with scoreboard queues for transmitted and received bytes.
module tb_kr580_uart_port;

  localparam int unsigned CPB  = 4;
  localparam logic [7:0]  BASE = 8'h10;

  logic       clk, rst, port_we, uart_rx, uart_tx, intr;
  logic [7:0] port_addr, port_wdata, port_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  kr580_uart_port #(.BASE(BASE), .CLKS_PER_BIT(CPB), .TX_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_we(port_we), .port_rdata(port_rdata), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .intr(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%b expected=1", tag, cond);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data, input int hold);
    @(negedge clk);
    port_addr  = addr;
    port_wdata = data;
    port_we    = 1'b1;
    repeat (hold) @(negedge clk);
    port_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_addr = addr;
    @(negedge clk);
    data = port_rdata;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    logic [9:0] sym;
    sym = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = sym[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  // Decodes every frame seen on uart_tx and compares it with the TX scoreboard
  initial begin
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check8("tx_start_bit", {7'b0, uart_tx}, 8'h00);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check8("tx_stop_bit", {7'b0, uart_tx}, 8'h01);
        e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        check8("tx_byte", b, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, e;
    logic       line [80];
    logic [9:0] frame;
    logic [3:0] grp;
    int         f, n;

    rst = 1'b1; port_we = 1'b0; port_addr = 8'h00; port_wdata = 8'h00; uart_rx = 1'b1;
    tick(2);
    check8("reset_uart_tx", {7'b0, uart_tx}, 8'h01);
    check8("reset_intr", {7'b0, intr}, 8'h00);
    check8("reset_rdata", port_rdata, 8'h00);
    rst = 1'b0;
    cpu_read(BASE + 8'd1, rd);
    check8("reset_status", rd, 8'h04);

    // One long write strobe must produce exactly one A5 frame
    tx_q.push_back(8'hA5);
    @(negedge clk);
    port_addr = BASE; port_wdata = 8'hA5; port_we = 1'b1;
    rd = 8'h00;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      line[i] = uart_tx;
      if (i == 3) port_we = 1'b0;
      if (i == 5) port_addr = BASE + 8'd1;
      if (i == 20) rd = port_rdata;
    end
    f = 0;
    while (f < 10 && line[f] !== 1'b0) f++;
    check_true("tx_a5_start_found", f < 10);
    check8("tx_status_busy", rd, 8'h0C);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 4; k++) grp[k] = line[f + s * 4 + k];
      check8($sformatf("tx_a5_sym%0d", s), {4'h0, grp}, frame[s] ? 8'h0F : 8'h00);
    end
    n = 0;
    for (int k = 40; k < 50; k++) if (line[f + k] !== 1'b1) n++;
    check8("tx_a5_single_frame", 8'(n), 8'h00);
    tick(5);

    // Fill FIFO while the first byte is on the line; 06 is dropped
    for (int b = 1; b <= 5; b++) tx_q.push_back(8'(b));
    for (int b = 1; b <= 6; b++) cpu_write(BASE, 8'(b), 1);
    cpu_read(BASE + 8'd1, rd);
    check8("tx_fifo_full_status", rd, 8'h0A);
    n = 0;
    while (tx_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    check8("tx_fifo_drained", 8'(tx_q.size()), 8'h00);
    tick(10);
    cpu_read(BASE + 8'd1, rd);
    check8("tx_idle_status", rd, 8'h04);

    // Receive path with rx interrupt
    cpu_write(BASE + 8'd2, 8'h02, 1);
    cpu_read(BASE + 8'd2, rd);
    check8("ctrl_rx_ie", rd, 8'h02);
    rx_q.push_back(8'h3C);
    send_serial(8'h3C, 1'b1);
    tick(6);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_valid_status", rd, 8'h05);
    check8("rx_intr_set", {7'b0, intr}, 8'h01);
    cpu_read(BASE, rd);
    e = rx_q.pop_front();
    check8("rx_data_3c", rd, e);
    cpu_write(BASE + 8'd1, 8'h01, 1);
    check8("rx_intr_cleared", {7'b0, intr}, 8'h00);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_popped_status", rd, 8'h04);

    // Overrun keeps the old byte, then a framing error
    rx_q.push_back(8'h3C);
    send_serial(8'h3C, 1'b1);
    tick(6);
    send_serial(8'h77, 1'b1);
    tick(6);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_ovr_status", rd, 8'h15);
    cpu_read(BASE, rd);
    e = rx_q.pop_front();
    check8("rx_ovr_data_kept", rd, e);
    send_serial(8'h55, 1'b0);
    tick(6);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_ferr_status", rd, 8'h35);
    cpu_write(BASE + 8'd1, 8'h02, 1);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_flags_cleared", rd, 8'h05);
    cpu_read(BASE, rd);
    check8("rx_data_after_clear", rd, 8'h3C);
    cpu_write(BASE + 8'd1, 8'h01, 1);

    // A one-clk low glitch must not start a frame
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    tick(50);
    cpu_read(BASE + 8'd1, rd);
    check8("rx_glitch_ignored", rd, 8'h04);
    cpu_read(8'h42, rd);
    check8("unmapped_read", rd, 8'h00);

    // TX-empty interrupt and ctrl readback masking
    cpu_write(BASE + 8'd2, 8'h04, 1);
    tick(2);
    check8("tx_intr_set", {7'b0, intr}, 8'h01);
    cpu_write(BASE + 8'd2, 8'hFF, 1);
    cpu_read(BASE + 8'd2, rd);
`ifdef UART_LOOPBACK_EN
    check8("ctrl_readback", rd, 8'h0E);
`else
    check8("ctrl_readback", rd, 8'h06);
`endif
    cpu_write(BASE + 8'd2, 8'h00, 1);
    tick(2);
    check8("intr_disabled", {7'b0, intr}, 8'h00);

`ifdef UART_LOOPBACK_EN
    cpu_write(BASE + 8'd2, 8'h08, 1);
    uart_rx = 1'b0;
    tx_q.push_back(8'h5A);
    rx_q.push_back(8'h5A);
    cpu_write(BASE, 8'h5A, 1);
    n = 0;
    while (tx_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check8("loop_tx_done", 8'(tx_q.size()), 8'h00);
    tick(8);
    cpu_read(BASE + 8'd1, rd);
    check8("loop_status", rd, 8'h05);
    cpu_read(BASE, rd);
    e = rx_q.pop_front();
    check8("loop_rx_data", rd, e);
    uart_rx = 1'b1;
    tick(2);
    cpu_write(BASE + 8'd2, 8'h00, 1);
    cpu_write(BASE + 8'd1, 8'h01, 1);
`endif

    tick(60);
    check8("tx_queue_empty", 8'(tx_q.size()), 8'h00);
    check8("rx_queue_empty", 8'(rx_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
